seq_mult_param: RTL and testbench



---
 rtl/seq_mult_param_if.sv | 33 +++
 rtl/seq_mult_param.sv | 134 +++++++++++++
 tb/tb_seq_mult_param.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: request/response bundle for the shared sequential multiplier.
// Signal names A, B, start, result, ready, busy and done match the multiplier's
// external port naming. dbg_state mirrors the multiplier FSM state for checkers.
//
// Handshake: a request is taken on a rising clk edge where start=1 and ready=1
// (A, B, signed_mode are sampled on that same edge). Nothing is queued; start
// seen with ready=0 is dropped. done is a one-cycle pulse that marks result as
// valid, and result then holds until the next accepted request.
interface seq_mult_param_if #(
  parameter int WIDTH = 24
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  // Requesting side (datapath controller)
  modport master (
    output start, signed_mode, A, B,
    input  result, ready, busy, done, dbg_state
  );

  // Multiplier side
  modport slave (
    input  start, signed_mode, A, B,
    output result, ready, busy, done, dbg_state
  );
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised radix-2 shift-add multiplier, one operation at a time.
// Unsigned or two's-complement operands selected per operation by signed_mode.
// FSM: IDLE -> CALC (WIDTH steps) -> DONE (one cycle) -> IDLE.
// Optional build macro SEQ_MULT_ZERO_SKIP_EN: a zero operand jumps straight from
// IDLE to DONE with result 0; without it zero operands take the full path.
// Reset is synchronous, active-high, and discards any in-flight operation.
module seq_mult_param #(
  parameter  int WIDTH = 24,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst,
  seq_mult_param_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // latched multiplicand
  logic [WIDTH-1:0]   hi_q, hi_d;         // upper half of the running partial product
  logic [WIDTH-1:0]   lo_q, lo_d;         // multiplier bits not yet consumed / low product bits
  logic               sgn_q, sgn_d;       // latched signed_mode
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // completed step count
  logic [2*WIDTH-1:0] result_q, result_d; // visible product, only updated at completion

  // Step arithmetic, one bit wider than the operand so the carry (unsigned) or
  // the true sign (signed) of the partial sum survives into the shift.
  logic [WIDTH:0]     hi_ext;
  logic [WIDTH:0]     mc_ext;
  logic [WIDTH:0]     sum;
  logic               last_step;

  // Datapath for one radix-2 step: conditional add, or subtract on the final
  // signed step because the multiplier MSB carries negative weight.
  always_comb begin
    hi_ext    = sgn_q ? {hi_q[WIDTH-1], hi_q} : {1'b0, hi_q};
    mc_ext    = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    sum       = hi_ext;
    if (lo_q[0]) begin
      if (sgn_q && last_step) begin
        sum = hi_ext - mc_ext;
      end else begin
        sum = hi_ext + mc_ext;
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          mcand_d = bus.A;
          lo_d    = bus.B;
          sgn_d   = bus.signed_mode;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef SEQ_MULT_ZERO_SKIP_EN
          // A zero operand makes the product known immediately.
          if ((bus.A == '0) || (bus.B == '0)) begin
            result_d = '0;
            state_d  = S_DONE;
          end
`endif
        end
      end

      S_CALC: begin
        bus.busy = 1'b1;
        // Shift the partial sum right by one; the bit falling out of hi
        // becomes a finished low product bit at the top of lo.
        hi_d  = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          result_d = {sum[WIDTH:1], sum[0], lo_q[WIDTH-1:1]};
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset overrides any request arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed tests for seq_mult_param at WIDTH=24 and WIDTH=8.
// Latency is counted as the index of the cycle in which done is seen, where
// cycle 1 is the one immediately after the accepting edge.
// Honours SEQ_MULT_ZERO_SKIP_EN for the expected zero-operand latency.
module tb_seq_mult_param;

  localparam int LAT24 = 25;
  localparam int LAT8  = 9;
`ifdef SEQ_MULT_ZERO_SKIP_EN
  localparam int     LATZ24  = 1;
  localparam int     LATZ8   = 1;
  localparam logic   ZBUSY   = 1'b0;
`else
  localparam int     LATZ24  = 25;
  localparam int     LATZ8   = 9;
  localparam logic   ZBUSY   = 1'b1;
`endif

  logic clk;
  logic rst24;
  logic rst8;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt24  = 0;

  seq_mult_param_if #(.WIDTH(24)) if24 ();
  seq_mult_param_if #(.WIDTH(8))  if8 ();

  seq_mult_param #(.WIDTH(24)) u_dut24 (.clk(clk), .rst(rst24), .bus(if24.slave));
  seq_mult_param #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst8),  .bus(if8.slave));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse of the 24-bit unit (used to prove reset drops one).
  always @(posedge clk) begin
    if (if24.done === 1'b1) done_cnt24 <= done_cnt24 + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic issue24(input logic sm, input logic [23:0] a, input logic [23:0] b);
    @(posedge clk); #1;
    if24.start = 1'b1; if24.signed_mode = sm; if24.A = a; if24.B = b;
    @(posedge clk); #1;
    if24.start = 1'b0;
    if24.signed_mode = 1'($urandom_range(0, 1));
    if24.A = 24'($urandom);
    if24.B = 24'($urandom);
  endtask

  task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    if8.start = 1'b1; if8.signed_mode = sm; if8.A = a; if8.B = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.signed_mode = 1'($urandom_range(0, 1));
    if8.A = 8'($urandom);
    if8.B = 8'($urandom);
  endtask

  task automatic wait24(input int lat0, output int lat, output logic saw_busy);
    lat = lat0;
    saw_busy = if24.busy;
    while (if24.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      saw_busy |= if24.busy;
    end
  endtask

  task automatic wait8(input int lat0, output int lat, output logic saw_busy);
    lat = lat0;
    saw_busy = if8.busy;
    while (if8.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      saw_busy |= if8.busy;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst24 = 1'b1; rst8 = 1'b1;
    if24.start = 1'b0; if24.signed_mode = 1'b0; if24.A = '0; if24.B = '0;
    if8.start  = 1'b0; if8.signed_mode  = 1'b0; if8.A  = '0; if8.B  = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({if24.ready, if24.busy, if24.done} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset24_flags: got rdy/busy/done=%b expected 100", {if24.ready, if24.busy, if24.done});
    end
    vectors++;
    if (if24.result !== 48'd0) begin
      miscompares++;
      $display("FAIL reset24_result: got %h expected 0", if24.result);
    end
    vectors++;
    if ({if8.ready, if8.busy, if8.done, if8.result} !== {3'b100, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset8: got flags=%b result=%h expected 100/0000", {if8.ready, if8.busy, if8.done}, if8.result);
    end
    rst24 = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    int   lat;
    logic sb;
    issue24(1'b0, 24'd2, 24'd2);
    wait24(1, lat, sb);
    vectors++;
    if (lat !== LAT24) begin
      miscompares++;
      $display("FAIL u_2x2_latency: got %0d expected %0d", lat, LAT24);
    end
    vectors++;
    if (if24.result !== 48'd4) begin
      miscompares++;
      $display("FAIL u_2x2_result: got %h expected %h", if24.result, 48'd4);
    end
    vectors++;
    if ({if24.ready, if24.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL u_done_flags: got rdy/busy=%b expected 00", {if24.ready, if24.busy});
    end
    @(posedge clk); #1;
    vectors++;
    if ({if24.ready, if24.busy, if24.done, if24.result} !== {3'b100, 48'd4}) begin
      miscompares++;
      $display("FAIL u_after_done: got flags=%b result=%h expected 100/4", {if24.ready, if24.busy, if24.done}, if24.result);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic sb;
    vectors++;
    if (if24.result !== 48'd4) begin
      miscompares++;
      $display("FAIL b2b_hold: got %h expected 4", if24.result);
    end
    issue24(1'b0, 24'd5, 24'd12);
    wait24(1, lat, sb);
    vectors++;
    if ({lat, if24.result} !== {LAT24, 48'd60}) begin
      miscompares++;
      $display("FAIL b2b_5x12: got lat=%0d result=%h expected lat=%0d result=%h", lat, if24.result, LAT24, 48'd60);
    end
  endtask

  task automatic test_signed();
    int   lat;
    logic sb;
    issue24(1'b1, 24'hFFFFFD, 24'd7);
    wait24(1, lat, sb);
    vectors++;
    if ({lat, if24.result} !== {LAT24, 48'hFFFFFFFFFFEB}) begin
      miscompares++;
      $display("FAIL s_m3x7: got lat=%0d result=%h expected lat=%0d result=ffffffffffeb", lat, if24.result, LAT24);
    end
    issue8(1'b1, 8'h80, 8'h80);
    wait8(1, lat, sb);
    vectors++;
    if ({lat, if8.result} !== {LAT8, 16'h4000}) begin
      miscompares++;
      $display("FAIL s_min_sq: got lat=%0d result=%h expected lat=%0d result=4000", lat, if8.result, LAT8);
    end
    issue8(1'b1, 8'hFF, 8'hFF);
    wait8(1, lat, sb);
    vectors++;
    if (if8.result !== 16'h0001) begin
      miscompares++;
      $display("FAIL s_m1xm1: got %h expected 0001", if8.result);
    end
    issue8(1'b1, 8'h80, 8'h7F);
    wait8(1, lat, sb);
    vectors++;
    if (if8.result !== 16'hC080) begin
      miscompares++;
      $display("FAIL s_min_x_max: got %h expected c080", if8.result);
    end
  endtask

  task automatic test_ignored_start();
    int   lat;
    logic sb;
    issue8(1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      if8.start = 1'b1; if8.A = 8'h03; if8.B = 8'h03;
      @(posedge clk); #1;
      vectors++;
      if ({if8.ready, if8.busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL ign_calc_flags[%0d]: got rdy/busy=%b expected 01", i, {if8.ready, if8.busy});
      end
    end
    if8.start = 1'b0;
    wait8(5, lat, sb);
    vectors++;
    if ({lat, if8.result} !== {LAT8, 16'hFE01}) begin
      miscompares++;
      $display("FAIL u_ff_x_ff: got lat=%0d result=%h expected lat=%0d result=fe01", lat, if8.result, LAT8);
    end
    // start during DONE must be dropped as well
    if8.start = 1'b1; if8.A = 8'h03; if8.B = 8'h03;
    @(posedge clk); #1;
    if8.start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({if8.ready, if8.busy, if8.done, if8.result} !== {3'b100, 16'hFE01}) begin
      miscompares++;
      $display("FAIL ign_done_start: got flags=%b result=%h expected 100/fe01", {if8.ready, if8.busy, if8.done}, if8.result);
    end
  endtask

  task automatic test_reset_mid_calc();
    int   lat;
    int   d0;
    logic sb;
    issue24(1'b0, 24'd100, 24'd200);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst24 = 1'b1;
    @(posedge clk); #1;
    rst24 = 1'b0;
    vectors++;
    if ({if24.ready, if24.busy, if24.done, if24.result} !== {3'b100, 48'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_calc: got flags=%b result=%h expected 100/0", {if24.ready, if24.busy, if24.done}, if24.result);
    end
    d0 = done_cnt24;
    repeat (30) begin
      @(posedge clk); #1;
    end
    vectors++;
    if ({done_cnt24, if24.ready} !== {d0, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_no_done: got done_pulses=%0d ready=%b expected %0d/1", done_cnt24, if24.ready, d0);
    end
    issue24(1'b0, 24'd1000, 24'd1000);
    wait24(1, lat, sb);
    vectors++;
    if ({lat, if24.result} !== {LAT24, 48'd1000000}) begin
      miscompares++;
      $display("FAIL rst_recover: got lat=%0d result=%h expected lat=%0d result=%h", lat, if24.result, LAT24, 48'd1000000);
    end
  endtask

  task automatic test_zero_operand();
    int   lat;
    logic sb;
    issue24(1'b0, 24'd0, 24'd9);
    wait24(1, lat, sb);
    vectors++;
    if ({lat, sb, if24.result} !== {LATZ24, ZBUSY, 48'd0}) begin
      miscompares++;
      $display("FAIL zero24: got lat=%0d busy_seen=%b result=%h expected lat=%0d busy_seen=%b result=0", lat, sb, if24.result, LATZ24, ZBUSY);
    end
    issue8(1'b1, 8'h5A, 8'h00);
    wait8(1, lat, sb);
    vectors++;
    if ({lat, sb, if8.result} !== {LATZ8, ZBUSY, 16'h0000}) begin
      miscompares++;
      $display("FAIL zero8: got lat=%0d busy_seen=%b result=%h expected lat=%0d busy_seen=%b result=0", lat, sb, if8.result, LATZ8, ZBUSY);
    end
    // non-zero timing right after a zero operation is unchanged
    @(posedge clk); #1;
    issue8(1'b0, 8'd13, 8'd11);
    wait8(1, lat, sb);
    vectors++;
    if ({lat, if8.result} !== {LAT8, 16'd143}) begin
      miscompares++;
      $display("FAIL after_zero: got lat=%0d result=%h expected lat=%0d result=%h", lat, if8.result, LAT8, 16'd143);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned_basic();
    test_back_to_back();
    test_signed();
    test_ignored_start();
    test_reset_mid_calc();
    test_zero_operand();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
